// File: rtl/regfile_wb_queue_if.sv
// Write-back queue bus: producer request channel, register-file write
// channel, and the two forwarding lookup ports with their results.
interface regfile_wb_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    // producer request channel
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rd;
    logic [DW-1:0] in_data;

    // register-file write channel
    logic          wr_en;
    logic          wr_ready;
    logic [AW-1:0] wr_rd;
    logic [DW-1:0] wr_data;

    // forwarding lookup
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          hit_a;
    logic          hit_b;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;

    // occupancy
    logic [CW-1:0] count;

    // environment side: drives requests, write acceptance and lookup indices
    modport master (
        output in_valid, in_rd, in_data, wr_ready, rs, rt,
        input  in_ready, wr_en, wr_rd, wr_data, hit_a, hit_b, fwd_a, fwd_b, count
    );

    // queue side
    modport slave (
        input  in_valid, in_rd, in_data, wr_ready, rs, rt,
        output in_ready, wr_en, wr_rd, wr_data, hit_a, hit_b, fwd_a, fwd_b, count
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order register write-back queue. Buffers (rd, data) requests in a
// circular buffer, drains the head into the register file one write per
// accepted cycle, and forwards the youngest queued value for rs/rt so
// readers never observe a stale register while its write is pending.
// Writes to r0 complete the handshake but are dropped (r0 is hardwired 0).
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input logic                 clk_i,
    input logic                 rst_i,    // synchronous, active low
    input logic                 flush_i,
    regfile_wb_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // entry storage
    logic [AW-1:0]    rd_q   [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    // pointers and occupancy; count disambiguates full from empty
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // handshake qualifiers
    logic in_ready_s;
    logic wr_en_s;
    logic push_s;
    logic pop_s;

    // lookup results before reset gating
    logic          hit_a_s, hit_b_s;
    logic [DW-1:0] fwd_a_s, fwd_b_s;

    // Handshake decode: ready ignores in_valid; a full queue never passes through.
    always_comb begin
        in_ready_s = 1'b0;
        wr_en_s    = 1'b0;
        if (rst_i && !flush_i && (count_q < CW'(DEPTH))) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        if (rst_i && (count_q != {CW{1'b0}})) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
        push_s = bus.in_valid && in_ready_s && (bus.in_rd != {AW{1'b0}});
        pop_s  = wr_en_s && bus.wr_ready;
    end

    // Next-state for pointers and occupancy; flush overrides push/pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = {PW{1'b0}};
            tail_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            if (push_s) begin
                tail_d = tail_q + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
                default: count_d = count_q;
            endcase
        end
    end

    // State update: reset beats flush, flush beats push/pop.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            valid_q <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= {AW{1'b0}};
                data_q[i] <= {DW{1'b0}};
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (flush_i) begin
                valid_q <= {DEPTH{1'b0}};
            end else begin
                // push and pop never share a slot: tail==head with room means empty
                if (push_s) begin
                    rd_q[tail_q]    <= bus.in_rd;
                    data_q[tail_q]  <= bus.in_data;
                    valid_q[tail_q] <= 1'b1;
                end
                if (pop_s) begin
                    valid_q[head_q] <= 1'b0;
                end
            end
        end
    end

    // Forwarding lookup: walk oldest to youngest so the last match wins.
    always_comb begin
        logic [PW-1:0] idx_v;
        logic          match_a_v;
        logic          match_b_v;
        idx_v     = {PW{1'b0}};
        match_a_v = 1'b0;
        match_b_v = 1'b0;
        hit_a_s   = 1'b0;
        hit_b_s   = 1'b0;
        fwd_a_s   = {DW{1'b0}};
        fwd_b_s   = {DW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx_v     = head_q + PW'(i);
            match_a_v = valid_q[idx_v] && (bus.rs != {AW{1'b0}}) && (rd_q[idx_v] == bus.rs);
            match_b_v = valid_q[idx_v] && (bus.rt != {AW{1'b0}}) && (rd_q[idx_v] == bus.rt);
            hit_a_s   = hit_a_s | match_a_v;
            hit_b_s   = hit_b_s | match_b_v;
            fwd_a_s   = match_a_v ? data_q[idx_v] : fwd_a_s;
            fwd_b_s   = match_b_v ? data_q[idx_v] : fwd_b_s;
        end
    end

    // Output drive: everything except count is forced to zero while in reset.
    always_comb begin
        bus.in_ready = in_ready_s;
        bus.wr_en    = wr_en_s;
        bus.count    = count_q;
        if (!rst_i) begin
            bus.wr_rd   = {AW{1'b0}};
            bus.wr_data = {DW{1'b0}};
            bus.hit_a   = 1'b0;
            bus.hit_b   = 1'b0;
            bus.fwd_a   = {DW{1'b0}};
            bus.fwd_b   = {DW{1'b0}};
        end else begin
            bus.wr_rd   = wr_en_s ? rd_q[head_q]   : {AW{1'b0}};
            bus.wr_data = wr_en_s ? data_q[head_q] : {DW{1'b0}};
            bus.hit_a   = hit_a_s;
            bus.hit_b   = hit_b_s;
            bus.fwd_a   = fwd_a_s;
            bus.fwd_b   = fwd_b_s;
        end
    end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of the write-back buffer.
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic clk;
    logic rst;
    logic flush;

    regfile_wb_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: pending writes, oldest at index 0
    logic [AW-1:0] m_rd[$];
    logic [DW-1:0] m_data[$];
    bit            m_known = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // youngest pending data for a register, by scanning the model queue
    task automatic ref_look(input logic [AW-1:0] idx, output logic h, output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
        if (rst && idx != 0) begin
            foreach (m_rd[k]) begin
                if (m_rd[k] == idx) begin
                    h = 1'b1;
                    d = m_data[k];
                end
            end
        end
    endtask

    // check all outputs against the model, then advance one clock;
    // returns at negedge+1 so outputs are settled for follow-up checks
    task automatic step();
        logic          er, ew, ha, hb;
        logic [AW-1:0] erd;
        logic [DW-1:0] edata, fa, fb;
        #1;
        er    = rst && !flush && (m_rd.size() < DEPTH);
        ew    = rst && (m_rd.size() != 0);
        erd   = ew ? m_rd[0]   : '0;
        edata = ew ? m_data[0] : '0;
        ref_look(bus.rs, ha, fa);
        ref_look(bus.rt, hb, fb);
        chk("in_ready", 32'(bus.in_ready), 32'(er));
        chk("wr_en",    32'(bus.wr_en),    32'(ew));
        chk("wr_rd",    32'(bus.wr_rd),    32'(erd));
        chk("wr_data",  bus.wr_data,       edata);
        chk("hit_a",    32'(bus.hit_a),    32'(ha));
        chk("hit_b",    32'(bus.hit_b),    32'(hb));
        chk("fwd_a",    bus.fwd_a,         fa);
        chk("fwd_b",    bus.fwd_b,         fb);
        if (m_known) chk("count", 32'(bus.count), 32'(m_rd.size()));
        if (!rst) begin
            m_rd.delete();
            m_data.delete();
            m_known = 1'b1;
        end else if (flush) begin
            m_rd.delete();
            m_data.delete();
        end else begin
            if (ew && bus.wr_ready) begin
                void'(m_rd.pop_front());
                void'(m_data.pop_front());
            end
            if (bus.in_valid && er && bus.in_rd != 0) begin
                m_rd.push_back(bus.in_rd);
                m_data.push_back(bus.in_data);
            end
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_rd    = rd;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_rd    = '0;
        bus.in_data  = '0;
        bus.wr_ready = 1'b0;
        bus.rs       = '0;
        bus.rt       = '0;
        @(negedge clk);
        #1;

        // reset then idle
        step();
        step();
        rst = 1'b1;
        step();
        chk("idle_ready", 32'(bus.in_ready), 32'd1);
        chk("idle_count", 32'(bus.count), 32'd0);
        chk("idle_wr_en", 32'(bus.wr_en), 32'd0);

        // single write, forwarded, then committed
        push(5'd5, 32'hDEADBEEF);
        chk("single_wr_en", 32'(bus.wr_en), 32'd1);
        chk("single_wr_rd", 32'(bus.wr_rd), 32'd5);
        chk("single_wr_data", bus.wr_data, 32'hDEADBEEF);
        chk("single_count", 32'(bus.count), 32'd1);
        bus.rs = 5'd5;
        #1;
        chk("single_hit_a", 32'(bus.hit_a), 32'd1);
        chk("single_fwd_a", bus.fwd_a, 32'hDEADBEEF);
        bus.wr_ready = 1'b1;
        step();
        chk("single_done_count", 32'(bus.count), 32'd0);
        chk("single_done_hit", 32'(bus.hit_a), 32'd0);
        bus.wr_ready = 1'b0;

        // fill, backpressure, ordered drain
        for (int i = 1; i <= 4; i++) push(AW'(i), 32'(i * 32'h11));
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_rd    = 5'd9;
        bus.in_data  = 32'h55;
        step();
        chk("held_count", 32'(bus.count), 32'd4);
        bus.in_valid = 1'b0;
        bus.wr_ready = 1'b1;
        #1;
        chk("full_ready_wr_ready", 32'(bus.in_ready), 32'd0);
        chk("drain_first_rd", 32'(bus.wr_rd), 32'd1);
        step();
        chk("ready_after_pop", 32'(bus.in_ready), 32'd1);
        chk("drain_second_rd", 32'(bus.wr_rd), 32'd2);
        step();
        step();
        step();
        chk("drained_count", 32'(bus.count), 32'd0);
        bus.wr_ready = 1'b0;

        // youngest-match forwarding
        push(5'd7, 32'h100);
        push(5'd7, 32'h200);
        bus.rt = 5'd7;
        #1;
        chk("young_hit_b", 32'(bus.hit_b), 32'd1);
        chk("young_fwd_b", bus.fwd_b, 32'h200);
        bus.wr_ready = 1'b1;
        step();
        chk("young_fwd_b_pop1", bus.fwd_b, 32'h200);
        step();
        chk("young_hit_b_pop2", 32'(bus.hit_b), 32'd0);
        bus.wr_ready = 1'b0;

        // r0 writes are accepted but dropped
        bus.rs = 5'd0;
        push(5'd0, 32'hFFFF);
        chk("r0_count", 32'(bus.count), 32'd0);
        chk("r0_hit_a", 32'(bus.hit_a), 32'd0);

        // flush wins over concurrent push and pop
        push(5'd10, 32'hA);
        push(5'd11, 32'hB);
        push(5'd12, 32'hC);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_rd    = 5'd13;
        bus.in_data  = 32'hD;
        bus.wr_ready = 1'b1;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_wr_en", 32'(bus.wr_en), 32'd0);

        // overlapped push/pop across pointer wrap
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_rd    = AW'((i % 31) + 1);
            bus.in_data  = 32'(i + 1);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        step();
        bus.wr_ready = 1'b0;

        // reset in the middle of operation
        push(5'd20, 32'h20);
        push(5'd21, 32'h21);
        push(5'd22, 32'h22);
        chk("pre_reset_count", 32'(bus.count), 32'd3);
        bus.rs = 5'd20;
        bus.rt = 5'd22;
        rst    = 1'b0;
        step();
        chk("reset_count", 32'(bus.count), 32'd0);
        chk("reset_wr_en", 32'(bus.wr_en), 32'd0);
        chk("reset_hit_a", 32'(bus.hit_a), 32'd0);
        chk("reset_hit_b", 32'(bus.hit_b), 32'd0);
        rst = 1'b1;
        step();

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 49) != 0);
            flush        = ($urandom_range(0, 19) == 0);
            bus.in_valid = $urandom_range(0, 1) != 0;
            bus.in_rd    = AW'($urandom_range(0, 7));
            bus.in_data  = $urandom;
            bus.wr_ready = ($urandom_range(0, 2) == 0);
            bus.rs       = AW'($urandom_range(0, 7));
            bus.rt       = AW'($urandom_range(0, 7));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-side companion to the per-register read/write slices of the multicycle datapath.
- Accepts register write-back requests (rd, data) from the execute/memory stages over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains the FIFO into the register file one write per accepted cycle.
- Provides combinational pending-write lookup and forwarding for the rs/rt read ports, so reads never see stale data while a write is queued.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16.
- AW, 5, register index width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- flush  in  1  synchronous clear of all queued writes.
- in_valid  in  1  producer has a write-back request.
- in_ready  out  1  queue can accept a request this cycle.
- in_rd  in  AW  destination register index.
- in_data  in  DW  write data.
- wr_en  out  1  head entry is presented to the register file.
- wr_ready  in  1  register file accepts the presented write this cycle.
- wr_rd  out  AW  head destination index.
- wr_data  out  DW  head write data.
- rs  in  AW  read port A index.
- rt  in  AW  read port B index.
- hit_a  out  1  a queued write targets rs.
- hit_b  out  1  a queued write targets rt.
- fwd_a  out  DW  youngest queued data for rs.
- fwd_b  out  DW  youngest queued data for rt.
- count  out  clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Storage: circular buffer of DEPTH entries (rd, data, valid), with head pointer, tail pointer and occupancy counter.
- Reset (rst==0 at a clk edge):
  - all valid bits 0; head, tail and count 0.
  - While rst==0: in_ready=0, wr_en=0, hit_a=hit_b=0.
  - wr_rd, wr_data, fwd_a and fwd_b output 0.
- Priority per edge: reset > flush > push/pop.
- Push: in_valid && in_ready at an edge.
  - in_ready = rst && !flush && (count<DEPTH); combinational, no dependence on in_valid.
  - Push with in_rd==0 is accepted (handshake completes) but not enqueued; count unchanged. r0 is hardwired zero.
  - Push with in_rd!=0 writes the entry at tail; tail advances modulo DEPTH; count+1.
- Pop:
  - wr_en = (count!=0); wr_rd and wr_data show the head entry combinationally.
  - Pop occurs when wr_en && wr_ready at an edge: head entry invalidated, head advances modulo DEPTH, count-1.
  - When empty, wr_rd=0 and wr_data=0.
- Simultaneous push and pop in the same cycle: count unchanged. Both pointers advance; order is preserved.
- When full, in_ready=0 even if wr_ready=1 in that cycle; there is no same-cycle pass-through.
- Latency: a write accepted at edge N appears on wr_en after edge N if the queue was empty. The earliest register-file commit is edge N+1.
- Flush: at the edge, all entries are invalidated, pointers and count go to 0, and any concurrent push or pop is ignored. in_ready is 0 during the flush cycle.
- Lookup (combinational over all valid entries, including the head):
  - hit_a=1 iff rs!=0 and some valid entry has rd==rs.
  - fwd_a = data of the youngest matching entry (closest to tail), else 0. Same rules for rt, hit_b and fwd_b.
  - Lookup reflects state before the current edge. A same-cycle push is not visible; an entry popped at an edge is not visible after that edge.
- Pointer wrap: pointers are AW-independent, log2(DEPTH) bits and wrap naturally. count distinguishes full from empty.
- count never exceeds DEPTH and never underflows. A pop with count==0 is impossible because wr_en=0.

Test Plan:
- Reset, then idle: rst=0 for 2 cycles then 1 -> in_ready=1, wr_en=0, count=0, hit_a=0.
- Single write: push rd=5, data=0xDEADBEEF with wr_ready=0 -> next cycle wr_en=1, wr_rd=5, wr_data=0xDEADBEEF, count=1. Set rs=5 -> hit_a=1, fwd_a=0xDEADBEEF. Raise wr_ready -> after the edge count=0, hit_a=0.
- Fill and backpressure:
  - With wr_ready=0, push rd=1..4 (data 0x11..0x44) -> count=4, in_ready=0; a 5th request is held off.
  - Then wr_ready=1 -> writes drain in order 1,2,3,4 on consecutive cycles.
  - in_ready returns to 1 after the first pop.
- Youngest-match forwarding: with wr_ready=0, push rd=7/0x100 then rd=7/0x200, and rt=7 -> hit_b=1, fwd_b=0x200. After one pop, fwd_b is still 0x200; after the second pop, hit_b=0.
- r0 and flush:
  - Push rd=0/0xFFFF -> handshake completes, count stays 0, rs=0 gives hit_a=0.
  - Push 3 entries, then assert flush together with in_valid=1 and wr_ready=1 -> count=0, no write issued, no entry added.
- Mid-operation reset and wrap:
  - Run 10 push/pop-overlapped cycles (pointers wrap past DEPTH) with data incrementing from 0x1 -> every register-file write matches its push order.
  - Assert rst=0 with count=3 -> next cycle count=0, wr_en=0, all hits 0.
